// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word request at a time to
// instruction memory, buffers responses in a small in-order queue for Decode
// and services Execute redirects (flush, drop in-flight response, restart).
package fetch_pkg;
  typedef enum logic [1:0] {
    STEP_FORWARD                = 2'b00,
    JUMP_TO_LABEL               = 2'b01,
    JUMP_TO_CALCULATED_REGISTER = 2'b10
  } PC_Next_Select_Case;
endpackage

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IQ_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  PC_Next_Select_Case PCNext_Select,
  input  logic [31:0]        Target_Address,
  input  logic [31:0]        ALUResult_to_Fetch,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [31:0]        imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [31:0]        imem_rsp_data,
  output logic               if_valid,
  output logic [31:0]        if_instr,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_pc4,
  input  logic               id_ready,
  output logic               fetch_fault
);

  localparam int          PW   = $clog2(IQ_DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(IQ_DEPTH);

  typedef enum logic [1:0] {RUN, WAIT, FAULT} state_t;

  state_t        state, state_next;
  logic [31:0]   pc, pc_next;
  logic [31:0]   req_pc;
  logic          drop, drop_next;
  logic          started;
  logic [PW:0]   count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   iq_instr [IQ_DEPTH];
  logic [31:0]   iq_pc    [IQ_DEPTH];

  logic          redirect;
  logic [31:0]   target;
  logic          req_valid;
  logic          req_fire;
  logic          enq;
  logic          deq;
  logic          flush;

  assign redirect = (PCNext_Select != STEP_FORWARD);

  // Select the redirect target; register-based jumps clear bit 0
  always_comb begin
    target = Target_Address;
    if (PCNext_Select == JUMP_TO_CALCULATED_REGISTER)
      target = ALUResult_to_Fetch & 32'hFFFF_FFFE;
  end

  // Next-state, request and queue-control decode; redirect overrides everything
  always_comb begin
    state_next = state;
    pc_next    = pc;
    drop_next  = drop;
    req_valid  = 1'b0;
    req_fire   = 1'b0;
    enq        = 1'b0;
    flush      = 1'b0;
    case (state)
      RUN: begin
        if (redirect) begin
          flush = 1'b1;
          if (target[1]) state_next = FAULT;
          else           pc_next    = target;
        end else begin
          // started keeps the request line low until the first clock after reset release
          req_valid = started && (count < FULL);
          req_fire  = req_valid && imem_req_ready;
          if (req_fire) begin
            pc_next    = pc + 32'd4;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (redirect) begin
          flush = 1'b1;
          if (target[1]) begin
            state_next = FAULT;
            drop_next  = 1'b0;
          end else begin
            pc_next = target;
            if (imem_rsp_valid) begin
              state_next = RUN;
              drop_next  = 1'b0;
            end else begin
              drop_next  = 1'b1;
            end
          end
        end else if (imem_rsp_valid) begin
          enq        = !drop;
          drop_next  = 1'b0;
          state_next = RUN;
        end
      end
      FAULT: begin
        flush = 1'b1;
      end
      default: begin
        state_next = FAULT;
        flush      = 1'b1;
      end
    endcase
  end

  assign deq = if_valid && id_ready && !flush;

  // FSM, PC and drop-flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      pc      <= RESET_PC;
      drop    <= 1'b0;
      started <= 1'b0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      drop    <= drop_next;
      started <= 1'b1;
    end
  end

  // Remember the PC of the request in flight so its response can be tagged
  always_ff @(posedge clk) begin
    if (req_fire) req_pc <= pc;
  end

  // Queue pointers and occupancy; flush resets all three
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage written on enqueue only
  always_ff @(posedge clk) begin
    if (enq) begin
      iq_instr[wr_ptr] <= imem_rsp_data;
      iq_pc[wr_ptr]    <= req_pc;
    end
  end

  assign if_valid       = (count != '0);
  assign if_instr       = if_valid ? iq_instr[rd_ptr] : 32'h0;
  assign if_pc          = if_valid ? iq_pc[rd_ptr] : 32'h0;
  assign if_pc4         = if_valid ? (iq_pc[rd_ptr] + 32'd4) : 32'h0;
  assign imem_req_valid = req_valid;
  assign imem_addr      = req_valid ? pc : 32'h0;
  assign fetch_fault    = (state == FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory model with random latency answers accepted
// requests in order, and a stream model tracks which PC Decode must see next.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          IQ_DEPTH = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  PC_Next_Select_Case PCNext_Select = STEP_FORWARD;
  logic [31:0]        Target_Address = 32'h0;
  logic [31:0]        ALUResult_to_Fetch = 32'h0;
  logic               imem_req_valid;
  logic               imem_req_ready = 1'b0;
  logic [31:0]        imem_addr;
  logic               imem_rsp_valid = 1'b0;
  logic [31:0]        imem_rsp_data = 32'h0;
  logic               if_valid;
  logic [31:0]        if_instr;
  logic [31:0]        if_pc;
  logic [31:0]        if_pc4;
  logic               id_ready = 1'b0;
  logic               fetch_fault;

  fetch_unit #(.RESET_PC(RESET_PC), .IQ_DEPTH(IQ_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .PCNext_Select(PCNext_Select), .Target_Address(Target_Address),
    .ALUResult_to_Fetch(ALUResult_to_Fetch),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc4(if_pc4), .id_ready(id_ready),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          n_req = 0;
  int          fixed_lat = 1;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] exp_req = RESET_PC;
  bit          faulted = 1'b0;
  bit          chk_empty = 1'b0;
  bit          chk_req = 1'b0;
  logic [31:0] mq_addr [$];
  int          mq_due [$];
  logic [31:0] cons_pc [$];
  logic [31:0] req_log [$];

  // Memory contents: a distinct word per address
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle: check at the negedge, then advance memory after the posedge
  task automatic tick();
    bit          redir;
    bit          fire;
    bit          faulted_n;
    logic [31:0] tgt;
    logic [31:0] junk;
    int          lat;
    @(negedge clk);
    faulted_n = 1'b0;
    redir = (PCNext_Select != STEP_FORWARD);
    tgt = (PCNext_Select == JUMP_TO_CALCULATED_REGISTER) ?
          {ALUResult_to_Fetch[31:1], 1'b0} : Target_Address;
    if (faulted) begin
      n_checks++;
      if (fetch_fault !== 1'b1) begin n_errors++; $display("FAIL fault_sticky: got %0b want 1", fetch_fault); end
      n_checks++;
      if (if_valid !== 1'b0) begin n_errors++; $display("FAIL fault_if_valid: got %0b want 0", if_valid); end
      n_checks++;
      if (imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL fault_no_req: got %0b want 0", imem_req_valid); end
      chk_empty = 1'b0;
      chk_req   = 1'b0;
    end else begin
      n_checks++;
      if (fetch_fault !== 1'b0) begin n_errors++; $display("FAIL no_fault: got %0b want 0", fetch_fault); end
      if (chk_empty) begin
        n_checks++;
        if (if_valid !== 1'b0) begin n_errors++; $display("FAIL flush_empty: if_valid got %0b want 0", if_valid); end
      end
      if (chk_req) begin
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== exp_req) begin
          n_errors++; $display("FAIL redirect_latency: valid=%0b addr=%h want valid=1 addr=%h", imem_req_valid, imem_addr, exp_req);
        end
      end
      if (redir) begin
        n_checks++;
        if (imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL redirect_req_low: got %0b want 0", imem_req_valid); end
      end
      fire = imem_req_valid && imem_req_ready;
      if (fire) begin
        n_checks++;
        if (imem_addr !== exp_req) begin n_errors++; $display("FAIL req_addr: got %h want %h", imem_addr, exp_req); end
        req_log.push_back(imem_addr);
        n_req++;
        lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
        mq_addr.push_back(imem_addr);
        mq_due.push_back(cyc + lat);
        exp_req = exp_req + 32'd4;
      end
      if (if_valid && !redir) begin
        n_checks++;
        if (if_pc !== exp_pc || if_instr !== instr_of(exp_pc) || if_pc4 !== exp_pc + 32'd4) begin
          n_errors++;
          $display("FAIL head: pc=%h instr=%h pc4=%h want pc=%h instr=%h pc4=%h",
                   if_pc, if_instr, if_pc4, exp_pc, instr_of(exp_pc), exp_pc + 32'd4);
        end
        if (id_ready) begin
          cons_pc.push_back(if_pc);
          exp_pc = exp_pc + 32'd4;
        end
      end
      chk_empty = redir;
      chk_req   = redir && !tgt[1] && (mq_addr.size() == 0);
      if (redir) begin
        if (tgt[1]) faulted_n = 1'b1;
        else begin
          exp_pc  = tgt;
          exp_req = tgt;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    faulted = faulted | faulted_n;
    PCNext_Select = STEP_FORWARD;
    junk = $urandom;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = junk;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    PCNext_Select = STEP_FORWARD;
    imem_rsp_valid = 1'b0;
    #1;
    n_checks++;
    if ({imem_req_valid, if_valid, fetch_fault} !== 3'b000) begin
      n_errors++; $display("FAIL reset_ctrl: req=%0b if_valid=%0b fault=%0b want 0 0 0", imem_req_valid, if_valid, fetch_fault);
    end
    n_checks++;
    if (imem_addr !== 32'h0) begin n_errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    n_checks++;
    if (if_instr !== 32'h0 || if_pc !== 32'h0 || if_pc4 !== 32'h0) begin
      n_errors++; $display("FAIL reset_head: instr=%h pc=%h pc4=%h want 0", if_instr, if_pc, if_pc4);
    end
    mq_addr.delete(); mq_due.delete(); cons_pc.delete(); req_log.delete();
    faulted = 1'b0; chk_empty = 1'b0; chk_req = 1'b0; n_req = 0;
    exp_pc = RESET_PC; exp_req = RESET_PC;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    apply_reset();
  endtask

  task automatic test_basic();
    int k;
    imem_req_ready = 1'b1; id_ready = 1'b1; fixed_lat = 1;
    k = 0;
    while (cons_pc.size() < 3 && k < 40) begin tick(); k++; end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= cons_pc.size() || cons_pc[i] !== RESET_PC + 32'(4 * i)) begin
        n_errors++; $display("FAIL basic_if_pc[%0d]: got %h (n=%0d) want %h", i, (i < cons_pc.size()) ? cons_pc[i] : 32'hx, cons_pc.size(), RESET_PC + 32'(4 * i));
      end
      n_checks++;
      if (i >= req_log.size() || req_log[i] !== RESET_PC + 32'(4 * i)) begin
        n_errors++; $display("FAIL basic_req_addr[%0d]: got %h (n=%0d) want %h", i, (i < req_log.size()) ? req_log[i] : 32'hx, req_log.size(), RESET_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    int k;
    imem_req_ready = 1'b1; id_ready = 1'b0; fixed_lat = 1;
    for (int i = 0; i < 20; i++) tick();
    n_checks++;
    if (n_req !== IQ_DEPTH) begin n_errors++; $display("FAIL bp_req_count: got %0d want %0d", n_req, IQ_DEPTH); end
    n_checks++;
    if (imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL bp_req_stall: got %0b want 0", imem_req_valid); end
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== RESET_PC) begin n_errors++; $display("FAIL bp_head: valid=%0b pc=%h want 1 %h", if_valid, if_pc, RESET_PC); end
    id_ready = 1'b1;
    k = 0;
    while (n_req < 3 && k < 20) begin tick(); k++; end
    n_checks++;
    if (req_log.size() < 3 || req_log[2] !== RESET_PC + 32'd8) begin
      n_errors++; $display("FAIL bp_resume: n=%0d addr=%h want %h", req_log.size(), (req_log.size() > 2) ? req_log[2] : 32'hx, RESET_PC + 32'd8);
    end
  endtask

  task automatic test_redirect_label();
    int k;
    imem_req_ready = 1'b1; id_ready = 1'b1; fixed_lat = 3;
    k = 0;
    while (!(mq_addr.size() != 0 && !imem_rsp_valid) && k < 30) begin tick(); k++; end
    n_checks++;
    if (mq_addr.size() == 0) begin n_errors++; $display("FAIL label_setup: outstanding got 0 want 1"); end
    PCNext_Select = JUMP_TO_LABEL; Target_Address = 32'h100;
    cons_pc.delete();
    tick();
    n_checks++;
    if (if_valid !== 1'b0) begin n_errors++; $display("FAIL label_flush: if_valid got %0b want 0", if_valid); end
    k = 0;
    while (cons_pc.size() < 1 && k < 40) begin tick(); k++; end
    n_checks++;
    if (cons_pc.size() < 1 || cons_pc[0] !== 32'h100) begin
      n_errors++; $display("FAIL label_first_pc: got %h (n=%0d) want 00000100", (cons_pc.size() > 0) ? cons_pc[0] : 32'hx, cons_pc.size());
    end
  endtask

  task automatic test_redirect_with_rsp();
    int k;
    imem_req_ready = 1'b1; id_ready = 1'b0; fixed_lat = 1;
    PCNext_Select = JUMP_TO_LABEL; Target_Address = 32'h200;
    tick();
    k = 0;
    while (!(imem_rsp_valid && if_valid) && k < 30) begin tick(); k++; end
    n_checks++;
    if (!(imem_rsp_valid && if_valid)) begin n_errors++; $display("FAIL rsp_setup: rsp=%0b if_valid=%0b want 1 1", imem_rsp_valid, if_valid); end
    id_ready = 1'b1;
    PCNext_Select = JUMP_TO_LABEL; Target_Address = 32'h300;
    cons_pc.delete();
    tick();
    n_checks++;
    if (if_valid !== 1'b0) begin n_errors++; $display("FAIL rsp_flush: if_valid got %0b want 0", if_valid); end
    k = 0;
    while (cons_pc.size() < 2 && k < 40) begin tick(); k++; end
    n_checks++;
    if (cons_pc.size() < 2 || cons_pc[0] !== 32'h300 || cons_pc[1] !== 32'h304) begin
      n_errors++; $display("FAIL rsp_stream: got %h %h (n=%0d) want 00000300 00000304",
                           (cons_pc.size() > 0) ? cons_pc[0] : 32'hx, (cons_pc.size() > 1) ? cons_pc[1] : 32'hx, cons_pc.size());
    end
  endtask

  task automatic test_calc_reg();
    int k;
    imem_req_ready = 1'b0; id_ready = 1'b0; fixed_lat = 1;
    k = 0;
    while (!(mq_addr.size() == 0 && !imem_rsp_valid) && k < 10) begin tick(); k++; end
    imem_req_ready = 1'b1;
    PCNext_Select = JUMP_TO_CALCULATED_REGISTER; ALUResult_to_Fetch = 32'h205; Target_Address = 32'hABC0;
    tick();
    tick();
    tick();
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h204 || if_instr !== instr_of(32'h204) || fetch_fault !== 1'b0) begin
      n_errors++; $display("FAIL calc_latency: valid=%0b pc=%h instr=%h fault=%0b want 1 00000204 %h 0",
                           if_valid, if_pc, if_instr, fetch_fault, instr_of(32'h204));
    end
  endtask

  task automatic test_pc_wrap();
    int k;
    imem_req_ready = 1'b1; id_ready = 1'b1; fixed_lat = 1;
    PCNext_Select = JUMP_TO_LABEL; Target_Address = 32'hFFFF_FFF8;
    cons_pc.delete();
    tick();
    k = 0;
    while (cons_pc.size() < 3 && k < 40) begin tick(); k++; end
    n_checks++;
    if (cons_pc.size() < 3 || cons_pc[1] !== 32'hFFFF_FFFC || cons_pc[2] !== 32'h0) begin
      n_errors++; $display("FAIL pc_wrap: got %h %h (n=%0d) want fffffffc 00000000",
                           (cons_pc.size() > 1) ? cons_pc[1] : 32'hx, (cons_pc.size() > 2) ? cons_pc[2] : 32'hx, cons_pc.size());
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    fixed_lat = 0;
    cons_pc.delete();
    for (int i = 0; i < 800; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 19) == 0) begin
        w = $urandom;
        w[1:0] = 2'b00;
        if ($urandom_range(0, 1) == 0) begin
          PCNext_Select = JUMP_TO_LABEL; Target_Address = w; ALUResult_to_Fetch = $urandom;
        end else begin
          PCNext_Select = JUMP_TO_CALCULATED_REGISTER; Target_Address = $urandom;
          ALUResult_to_Fetch = w | 32'($urandom_range(0, 1));
        end
      end
      tick();
    end
    n_checks++;
    if (cons_pc.size() < 50) begin n_errors++; $display("FAIL random_progress: consumed %0d want >= 50", cons_pc.size()); end
  endtask

  task automatic test_fault();
    int k;
    imem_req_ready = 1'b1; id_ready = 1'b0; fixed_lat = 1;
    for (int i = 0; i < 6; i++) tick();
    id_ready = 1'b1;
    PCNext_Select = JUMP_TO_CALCULATED_REGISTER; ALUResult_to_Fetch = 32'h206;
    tick();
    n_checks++;
    if (fetch_fault !== 1'b1 || if_valid !== 1'b0) begin
      n_errors++; $display("FAIL fault_set: fault=%0b if_valid=%0b want 1 0", fetch_fault, if_valid);
    end
    for (int i = 0; i < 30; i++) begin
      imem_req_ready = ($urandom_range(0, 1) != 0);
      if (i == 10) begin PCNext_Select = JUMP_TO_LABEL; Target_Address = 32'h400; end
      tick();
    end
    apply_reset();
    imem_req_ready = 1'b1; id_ready = 1'b1; fixed_lat = 1;
    k = 0;
    while (cons_pc.size() < 1 && k < 20) begin tick(); k++; end
    n_checks++;
    if (cons_pc.size() < 1 || cons_pc[0] !== RESET_PC) begin
      n_errors++; $display("FAIL fault_recover: got %h (n=%0d) want %h", (cons_pc.size() > 0) ? cons_pc[0] : 32'hx, cons_pc.size(), RESET_PC);
    end
  endtask

  task automatic test_reset_mid_wait();
    int k;
    imem_req_ready = 1'b1; id_ready = 1'b0; fixed_lat = 3;
    PCNext_Select = JUMP_TO_LABEL; Target_Address = 32'h500;
    tick();
    k = 0;
    while (!(if_valid && mq_addr.size() != 0 && !imem_rsp_valid) && k < 40) begin tick(); k++; end
    n_checks++;
    if (!(if_valid && mq_addr.size() != 0)) begin
      n_errors++; $display("FAIL midwait_setup: if_valid=%0b outstanding=%0d want 1 1", if_valid, mq_addr.size());
    end
    apply_reset();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    id_ready = 1'b1; fixed_lat = 1;
    tick();
    k = 0;
    while (cons_pc.size() < 2 && k < 20) begin tick(); k++; end
    n_checks++;
    if (cons_pc.size() < 2 || cons_pc[0] !== RESET_PC || cons_pc[1] !== RESET_PC + 32'd4) begin
      n_errors++; $display("FAIL midwait_restart: got %h %h (n=%0d) want %h %h",
                           (cons_pc.size() > 0) ? cons_pc[0] : 32'hx, (cons_pc.size() > 1) ? cons_pc[1] : 32'hx,
                           cons_pc.size(), RESET_PC, RESET_PC + 32'd4);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    apply_reset();
    test_backpressure();
    test_redirect_label();
    test_redirect_with_rsp();
    test_calc_reg();
    test_pc_wrap();
    test_random();
    test_fault();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
